// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning front end.
package button_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE,
    ST_HIGH,
    ST_FALL
  } btn_state_t;

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

endpackage

// File: rtl/button_conditioner_if.sv
// Button pins in, conditioned levels/pulses/direction out.
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_toggle;
  logic [1:0]       dir_code;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_toggle, dir_code
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_toggle, dir_code
  );
endinterface

// File: rtl/button_debounce_ch.sv
// One button channel: synchroniser, debounce FSM with stability counter, edge pulses, toggle.
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic level_next_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  btn_state_t             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   toggle_q, toggle_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q ^ press_q;
    unique case (state_q)
      ST_LOW: begin
        if (s) state_d = ST_RISE;
      end
      ST_RISE: begin
        if (!s) begin
          state_d = ST_LOW;
        end else if (cnt_q == CntMax) begin
          state_d = ST_HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) state_d = ST_FALL;
      end
      ST_FALL: begin
        if (s) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CntMax) begin
          state_d   = ST_LOW;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign toggle_o     = toggle_q;

endmodule

// File: rtl/button_conditioner.sv
// N_BTN debounced button channels; channels 1/0 also form the motor direction code.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave btn
);

  logic [N_BTN-1:0] level, level_nxt, press, rel, tog;
  logic [1:0]       dir_q, dir_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .raw_i       (btn.btn_raw[i]),
      .level_o     (level[i]),
      .level_next_o(level_nxt[i]),
      .press_o     (press[i]),
      .release_o   (rel[i]),
      .toggle_o    (tog[i])
    );
  end

  // Registered from next-state levels so it moves in the same cycle as btn_level.
  always_comb begin
    dir_d = level_nxt[1:0];
    if (level_nxt[1:0] == 2'b11) dir_d = DIR_STOP;
  end

  always_ff @(posedge clk) begin
    if (reset) dir_q <= DIR_STOP;
    else       dir_q <= dir_d;
  end

  assign btn.btn_level   = level;
  assign btn.btn_press   = press;
  assign btn.btn_release = rel;
  assign btn.btn_toggle  = tog;
  assign btn.dir_code    = dir_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and random stimulus against a run-length debounce reference model.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int unsigned NBtn = 2;
  localparam int unsigned Sync = 2;
  localparam int unsigned Deb  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(NBtn)) bif ();

  button_conditioner #(
    .N_BTN          (NBtn),
    .SYNC_STAGES    (Sync),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (bif.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference: raw delayed by Sync edges; level flips once the delayed input
  // has disagreed with it for Deb+1 consecutive samples.
  logic [NBtn-1:0] m_hist [Sync];
  int              m_run  [NBtn];
  logic [NBtn-1:0] m_lvl, m_press, m_rel, m_tog;
  logic [1:0]      m_dir;

  task automatic model_step(input logic [NBtn-1:0] raw, input logic rst);
    logic [NBtn-1:0] s, nl;
    if (rst) begin
      for (int k = 0; k < Sync; k++) m_hist[k] = '0;
      for (int c = 0; c < NBtn; c++) m_run[c] = 0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_tog = '0; m_dir = DIR_STOP;
    end else begin
      s = m_hist[Sync-1];
      for (int k = Sync - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = raw;
      m_tog = m_tog ^ m_press;
      nl = m_lvl;
      for (int c = 0; c < NBtn; c++) begin
        if (s[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == Deb + 1) begin
            nl[c] = s[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_press = nl & ~m_lvl;
      m_rel   = m_lvl & ~nl;
      m_lvl   = nl;
      m_dir   = (nl[1:0] == 2'b11) ? DIR_STOP : nl[1:0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level",   32'(bif.btn_level),   32'(m_lvl));
    chk("press",   32'(bif.btn_press),   32'(m_press));
    chk("release", 32'(bif.btn_release), 32'(m_rel));
    chk("toggle",  32'(bif.btn_toggle),  32'(m_tog));
    chk("dir",     32'(bif.dir_code),    32'(m_dir));
    chk("press_and_release", 32'(bif.btn_press & bif.btn_release), 32'd0);
  endtask

  task automatic step(input logic [NBtn-1:0] raw, input logic rst);
    bif.btn_raw = raw;
    reset       = rst;
    @(posedge clk);
    model_step(raw, rst);
    #1;
    check_all();
  endtask

  int lat;
  int rel_cnt;
  int hold [NBtn];
  logic [NBtn-1:0] rnd_raw;

  initial begin
    bif.btn_raw = '0;
    reset       = 1'b1;

    // 1: reset with both raw inputs high
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1);
    for (int i = 0; i < 8; i++) step(2'b00, 1'b0);

    // 2: ch0 press latency
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step(2'b01, 1'b0);
      if (bif.btn_press[0] && lat == 0) lat = i;
    end
    chk("t2_latency", 32'(lat), 32'd7);
    chk("t2_dir", 32'(bif.dir_code), 32'(DIR_LEFT));

    // 3: 3-cycle glitch on ch1
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0);
    for (int i = 0; i < 10; i++) step(2'b01, 1'b0);
    chk("t3_level1", 32'(bif.btn_level[1]), 32'd0);

    // 4: both pressed, then release ch0 only
    for (int i = 0; i < 12; i++) step(2'b00, 1'b0);
    for (int i = 0; i < 12; i++) step(2'b11, 1'b0);
    chk("t4_both_dir", 32'(bif.dir_code), 32'(DIR_STOP));
    for (int i = 0; i < 7; i++) step(2'b10, 1'b0);
    chk("t4_right_dir", 32'(bif.dir_code), 32'(DIR_RIGHT));

    // 5: bounce before release
    for (int i = 0; i < 12; i++) step(2'b00, 1'b0);
    for (int i = 0; i < 10; i++) step(2'b01, 1'b0);
    rel_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 2; i++) begin step(2'b00, 1'b0); rel_cnt += int'(bif.btn_release[0]); end
      for (int i = 0; i < 2; i++) begin step(2'b01, 1'b0); rel_cnt += int'(bif.btn_release[0]); end
    end
    chk("t5_bounce_level", 32'(bif.btn_level[0]), 32'd1);
    for (int i = 0; i < 12; i++) begin
      step(2'b00, 1'b0);
      rel_cnt += int'(bif.btn_release[0]);
    end
    chk("t5_release_count", 32'(rel_cnt), 32'd1);

    // 6: reset mid-count, raw held high across it
    for (int i = 0; i < 5; i++) step(2'b01, 1'b0);
    for (int i = 0; i < 2; i++) step(2'b01, 1'b1);
    chk("t6_no_press", 32'(bif.btn_level[0]), 32'd0);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step(2'b01, 1'b0);
      if (bif.btn_press[0] && lat == 0) lat = i;
    end
    chk("t6_latency", 32'(lat), 32'd7);

    // Random hold lengths around the debounce threshold, occasional reset
    rnd_raw = '0;
    for (int c = 0; c < NBtn; c++) hold[c] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NBtn; c++) begin
        if (hold[c] == 0) begin
          rnd_raw[c] = ~rnd_raw[c];
          hold[c] = int'($urandom_range(1, 9));
        end
        hold[c]--;
      end
      step(rnd_raw, ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
